// File: rtl/multicycle_ctrl_if.sv
// Memory-side handshake bundle of the multicycle controller (instruction and data ports).
// Handshake: a request is held high until the matching ack; the transfer completes in the cycle where req=1 and ack=1, and an ack without its request is ignored.
`timescale 1ns/1ps
interface multicycle_ctrl_if;
   logic imem_req;
   logic imem_ack;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ack;

   modport master (
      output imem_req,
      output dmem_req,
      output dmem_we,
      input  imem_ack,
      input  dmem_ack
   );

   modport slave (
      input  imem_req,
      input  dmem_req,
      input  dmem_we,
      output imem_ack,
      output dmem_ack
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Sequencing FSM of the multicycle RV32I core: FETCH/DECODE/EXEC/MEM/WB with retired-instruction counter.
// Optional ack-timeout watchdog enabled by defining MC_CTRL_TIMEOUT_EN.
`timescale 1ns/1ps
module multicycle_ctrl #(
   parameter int CNT_W       = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   multicycle_ctrl_if.master    mem,
   output logic                 fetch_en,
   input  logic [6:0]           opcode,
   output logic                 alu_en,
   output logic                 reg_we,
   output logic                 next_pc_make,
   output logic                 halted,
   output logic                 illegal,
   output logic                 bus_err,
   output logic [2:0]           state,
   output logic [CNT_W-1:0]     instr_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("multicycle_ctrl: TIMEOUT_CYC must be >= 1");
   end

   state_t     state_q;
   state_t     state_d;
   logic [6:0] op_q;
   logic       is_store;
   logic       is_branch;
   logic       is_mem;
   logic       timeout;
   logic       illegal_q;

   function automatic logic is_legal(input logic [6:0] op);
      case (op)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
         OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_SYSTEM: is_legal = 1'b1;
         default:                                       is_legal = 1'b0;
      endcase
   endfunction

   assign state     = state_q;
   assign is_store  = (op_q == OP_STORE);
   assign is_branch = (op_q == OP_BRANCH);
   assign is_mem    = (op_q == OP_LOAD) || is_store;

`ifdef MC_CTRL_TIMEOUT_EN
   localparam int WAIT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

   logic [WAIT_W-1:0] wait_cnt;
   logic              waiting;
   logic              bus_err_q;

   // Counter is zero on every FETCH/MEM entry because it clears whenever not waiting.
   assign waiting = ((state_q == S_FETCH) && !mem.imem_ack) ||
                    ((state_q == S_MEM)   && !mem.dmem_ack);
   assign timeout = waiting && (wait_cnt == WAIT_LAST);
   assign bus_err = bus_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         wait_cnt  <= waiting ? wait_cnt + 1'b1 : '0;
         bus_err_q <= bus_err_q | timeout;
      end
   end
`else
   assign timeout = 1'b0;
   assign bus_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH: begin
            if (mem.imem_ack)  state_d = S_DECODE;
            else if (timeout)  state_d = S_HALT;
         end
         S_DECODE: begin
            if ((opcode == OP_SYSTEM) || !is_legal(opcode)) state_d = S_HALT;
            else                                            state_d = S_EXEC;
         end
         S_EXEC:   state_d = is_mem ? S_MEM : S_WB;
         S_MEM: begin
            if (mem.dmem_ack)  state_d = S_WB;
            else if (timeout)  state_d = S_HALT;
         end
         S_WB:     state_d = run ? S_FETCH : S_IDLE;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem.imem_req = 1'b0;
      mem.dmem_req = 1'b0;
      mem.dmem_we  = 1'b0;
      fetch_en     = 1'b0;
      alu_en       = 1'b0;
      reg_we       = 1'b0;
      next_pc_make = 1'b0;
      halted       = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem.imem_req = 1'b1;
            fetch_en     = mem.imem_ack;
         end
         S_EXEC:  alu_en = 1'b1;
         S_MEM: begin
            mem.dmem_req = 1'b1;
            mem.dmem_we  = is_store;
         end
         S_WB: begin
            next_pc_make = 1'b1;
            reg_we       = !(is_store || is_branch);
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   // Opcode is captured in DECODE so EXEC/MEM/WB do not depend on the IR staying put.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= '0;
         illegal_q <= 1'b0;
         instr_cnt <= '0;
      end else begin
         if (state_q == S_DECODE) begin
            op_q <= opcode;
            if (!is_legal(opcode)) illegal_q <= 1'b1;
         end
         if (state_q == S_WB) instr_cnt <= instr_cnt + 1'b1;
      end
   end

   assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (CNT_W=4, TIMEOUT_CYC=8); timeout scenario follows MC_CTRL_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
   localparam int CNT_W       = 4;
   localparam int TIMEOUT_CYC = 8;
   localparam int W           = CNT_W + 1;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             run;
   logic [6:0]       opcode;
   logic             fetch_en, alu_en, reg_we, next_pc_make;
   logic             halted, illegal, bus_err;
   logic [2:0]       state;
   logic [CNT_W-1:0] instr_cnt;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
      .mem          (bus),
      .fetch_en     (fetch_en),
      .opcode       (opcode),
      .alu_en       (alu_en),
      .reg_we       (reg_we),
      .next_pc_make (next_pc_make),
      .halted       (halted),
      .illegal      (illegal),
      .bus_err      (bus_err),
      .state        (state),
      .instr_cnt    (instr_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [W-1:0]     exp_q[$];
   logic [CNT_W-1:0] exp_cnt;

   int          n_fetch, n_alu, n_reg, n_npc, n_ireq, n_dreq, n_dwe_bad, n_overlap, trace_n;
   logic        dwe_seen;
   logic [47:0] trace_w;

   logic [6:0] legal_ops [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                 OP_LOAD, OP_STORE, OP_OPIMM, OP_OP};

   function automatic logic retires(input logic [6:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // Scoreboard: every retirement must match the oldest pending {reg_we, instr_cnt}.
   always begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && next_pc_make === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL retire_unexpected: got reg_we=%b cnt=%0d, required no retirement", reg_we, instr_cnt);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if ({reg_we, instr_cnt} !== e) begin
               errors++;
               $display("FAIL retire: got reg_we=%b cnt=%0d, required reg_we=%b cnt=%0d",
                        reg_we, instr_cnt, e[W-1], e[CNT_W-1:0]);
            end
         end
      end
   end

   task automatic clear_obs();
      n_fetch = 0; n_alu = 0; n_reg = 0; n_npc = 0; n_ireq = 0; n_dreq = 0;
      n_dwe_bad = 0; n_overlap = 0; trace_n = 0; dwe_seen = 1'b0; trace_w = '0;
   endtask

   task automatic sample_cycle();
      if (fetch_en)                      n_fetch++;
      if (alu_en)                        n_alu++;
      if (reg_we)                        n_reg++;
      if (next_pc_make)                  n_npc++;
      if (bus.imem_req)                  n_ireq++;
      if (bus.dmem_req)                  n_dreq++;
      if (bus.dmem_req && bus.dmem_we)   dwe_seen = 1'b1;
      if (bus.dmem_we && !bus.dmem_req)  n_dwe_bad++;
      if (bus.imem_req && bus.dmem_req)  n_overlap++;
      trace_w = {trace_w[44:0], state};
      trace_n++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      exp_q.delete();
      exp_cnt = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drives one instruction from its first FETCH cycle up to WB (or HALT); acks after iw/dw wait cycles.
   task automatic do_instr(input logic [6:0] op, input int iw, input int dw, input bit drop_in_exec);
      int ic = iw;
      int dc = dw;
      bit started = 1'b0;
      bit done = 1'b0;
      opcode = op;
      clear_obs();
      if (retires(op)) begin
         exp_q.push_back({!(op == OP_STORE || op == OP_BRANCH), exp_cnt});
         exp_cnt++;
      end
      for (int g = 0; g < 100 && !done; g++) begin
         @(negedge clk);
         bus.imem_ack = (state == 3'd1) && (ic == 0);
         bus.dmem_ack = (state == 3'd4) && (dc == 0);
         if (state == 3'd1 && ic > 0) ic--;
         if (state == 3'd4 && dc > 0) dc--;
         #1;
         if (state != 3'd0) started = 1'b1;
         if (started) begin
            sample_cycle();
            if (state == 3'd5 || state == 3'd6) done = 1'b1;
            if (state == 3'd3 && drop_in_exec) run = 1'b0;
         end
      end
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL instr_budget: op=%b got state=%0d, required WB or HALT within 100 cycles", op, state);
      end
   endtask

   task automatic test_reset();
      run = 1'b0; opcode = '0;
      do_reset();
      rst_n = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", state); end
      checks++;
      if (instr_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d, required 0", instr_cnt); end
      checks++;
      if ({bus.imem_req, bus.dmem_req, bus.dmem_we, fetch_en, alu_en, reg_we, next_pc_make,
           halted, illegal, bus_err} !== 10'b0) begin
         errors++; $display("FAIL reset_outputs: some output nonzero, required all 0");
      end
      rst_n = 1'b1;
   endtask

   task automatic test_op();
      run = 1'b1;
      do_instr(OP_OP, 0, 0, 1'b0);
      checks++;
      if (trace_n !== 4 || trace_w !== 48'({3'd1, 3'd2, 3'd3, 3'd5})) begin
         errors++; $display("FAIL op_trace: got n=%0d %h, required n=4 1,2,3,5", trace_n, trace_w);
      end
      checks++;
      if ({n_fetch, n_alu, n_reg, n_npc, n_dreq} !== {32'd1, 32'd1, 32'd1, 32'd1, 32'd0}) begin
         errors++; $display("FAIL op_pulses: got fetch=%0d alu=%0d reg=%0d npc=%0d dreq=%0d, required 1,1,1,1,0",
                             n_fetch, n_alu, n_reg, n_npc, n_dreq);
      end
      @(negedge clk); #1;
      checks++;
      if (state !== 3'd1) begin errors++; $display("FAIL op_next: got state=%0d, required 1", state); end
   endtask

   task automatic test_load_store();
      do_instr(OP_LOAD, 0, 3, 1'b0);
      checks++;
      if (trace_n !== 8 || trace_w !== 48'({3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5})) begin
         errors++; $display("FAIL load_trace: got n=%0d %h, required n=8 1,2,3,4,4,4,4,5", trace_n, trace_w);
      end
      checks++;
      if (n_dreq !== 4 || dwe_seen !== 1'b0 || n_reg !== 1) begin
         errors++; $display("FAIL load_mem: got dreq=%0d we=%b reg=%0d, required 4,0,1", n_dreq, dwe_seen, n_reg);
      end
      do_instr(OP_STORE, 1, 0, 1'b0);
      checks++;
      if (trace_n !== 6 || trace_w !== 48'({3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5})) begin
         errors++; $display("FAIL store_trace: got n=%0d %h, required n=6 1,1,2,3,4,5", trace_n, trace_w);
      end
      checks++;
      if (n_dreq !== 1 || dwe_seen !== 1'b1 || n_reg !== 0 || n_npc !== 1 || n_dwe_bad !== 0) begin
         errors++; $display("FAIL store_mem: got dreq=%0d we=%b reg=%0d npc=%0d webad=%0d, required 1,1,0,1,0",
                             n_dreq, dwe_seen, n_reg, n_npc, n_dwe_bad);
      end
   endtask

   task automatic test_branch();
      do_instr(OP_BRANCH, 0, 0, 1'b0);
      checks++;
      if (trace_n !== 4 || n_dreq !== 0 || n_reg !== 0 || n_npc !== 1 || n_alu !== 1) begin
         errors++; $display("FAIL branch: got n=%0d dreq=%0d reg=%0d npc=%0d alu=%0d, required 4,0,0,1,1",
                             trace_n, n_dreq, n_reg, n_npc, n_alu);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 12; k++) begin
         logic [6:0] op;
         int iw, dw, exp_len;
         bit is_mem;
         op = legal_ops[$urandom_range(0, 8)];
         iw = $urandom_range(0, 2);
         dw = $urandom_range(0, 2);
         is_mem = (op == OP_LOAD) || (op == OP_STORE);
         exp_len = 4 + iw + (is_mem ? 1 + dw : 0);
         do_instr(op, iw, dw, 1'b0);
         checks++;
         if (trace_n !== exp_len || n_npc !== 1 || n_fetch !== 1 || n_alu !== 1 || n_overlap !== 0) begin
            errors++; $display("FAIL b2b_%0d: op=%b got len=%0d npc=%0d fetch=%0d alu=%0d ovl=%0d, required len=%0d 1,1,1,0",
                                k, op, trace_n, n_npc, n_fetch, n_alu, n_overlap, exp_len);
         end
      end
   endtask

   task automatic test_run_drop();
      do_instr(OP_OPIMM, 0, 0, 1'b1);
      checks++;
      if (n_npc !== 1 || state !== 3'd5) begin
         errors++; $display("FAIL drop_retire: got npc=%0d state=%0d, required 1,5", n_npc, state);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (state !== 3'd0 || bus.imem_req !== 1'b0) begin
         errors++; $display("FAIL drop_idle: got state=%0d imem_req=%b, required 0,0", state, bus.imem_req);
      end
   endtask

   task automatic test_wrap();
      run = 1'b1;
      for (int k = 0; k < 20 && exp_cnt != {CNT_W{1'b1}}; k++) do_instr(OP_OP, 0, 0, 1'b0);
      @(negedge clk); #1;
      checks++;
      if (instr_cnt !== {CNT_W{1'b1}}) begin
         errors++; $display("FAIL wrap_pre: got %0d, required %0d", instr_cnt, {CNT_W{1'b1}});
      end
      do_instr(OP_LUI, 0, 0, 1'b0);
      @(negedge clk); #1;
      checks++;
      if (instr_cnt !== '0) begin errors++; $display("FAIL wrap: got %0d, required 0", instr_cnt); end
   endtask

   task automatic test_async_reset();
      do_instr(OP_JAL, 0, 0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (bus.imem_req !== 1'b1 || instr_cnt !== 4'd1) begin
         errors++; $display("FAIL areset_pre: got imem_req=%b cnt=%0d, required 1,1", bus.imem_req, instr_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.imem_req !== 1'b0 || state !== 3'd0 || instr_cnt !== '0) begin
         errors++; $display("FAIL areset: got imem_req=%b state=%0d cnt=%0d, required 0,0,0",
                             bus.imem_req, state, instr_cnt);
      end
      do_reset();
   endtask

   task automatic test_system_halt();
      run = 1'b1;
      do_instr(OP_SYSTEM, 0, 0, 1'b0);
      checks++;
      if (trace_n !== 3 || state !== 3'd6 || halted !== 1'b1 || illegal !== 1'b0 || n_alu !== 0) begin
         errors++; $display("FAIL system_halt: got n=%0d state=%0d halted=%b illegal=%b alu=%0d, required 3,6,1,0,0",
                             trace_n, state, halted, illegal, n_alu);
      end
      do_reset();
   endtask

   task automatic test_illegal_halt();
      int not_halt = 0;
      run = 1'b1;
      do_instr(7'b1111111, 0, 0, 1'b0);
      checks++;
      if (state !== 3'd6 || halted !== 1'b1 || illegal !== 1'b1 || bus_err !== 1'b0) begin
         errors++; $display("FAIL illegal_halt: got state=%0d halted=%b illegal=%b bus_err=%b, required 6,1,1,0",
                             state, halted, illegal, bus_err);
      end
      clear_obs();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         run = 1'($urandom_range(0, 1));
         bus.imem_ack = 1'($urandom_range(0, 1));
         bus.dmem_ack = 1'($urandom_range(0, 1));
         #1;
         sample_cycle();
         if (state !== 3'd6 || halted !== 1'b1) not_halt++;
      end
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      checks++;
      if (not_halt != 0 || n_fetch + n_alu + n_reg + n_npc + n_ireq + n_dreq != 0) begin
         errors++; $display("FAIL halt_sticky: got left_halt=%0d activity=%0d, required 0,0",
                             not_halt, n_fetch + n_alu + n_reg + n_npc + n_ireq + n_dreq);
      end
      do_reset();
   endtask

   task automatic test_timeout();
      int req_cyc = 0;
      run = 1'b1;
      bus.imem_ack = 1'b0;
`ifdef MC_CTRL_TIMEOUT_EN
      for (int k = 0; k < 50 && state !== 3'd6; k++) begin
         @(negedge clk); #1;
         if (bus.imem_req) req_cyc++;
      end
      checks++;
      if (req_cyc != TIMEOUT_CYC || state !== 3'd6 || bus_err !== 1'b1 || halted !== 1'b1 ||
          illegal !== 1'b0 || bus.imem_req !== 1'b0) begin
         errors++; $display("FAIL timeout: got req_cyc=%0d state=%0d bus_err=%b halted=%b illegal=%b req=%b, required %0d,6,1,1,0,0",
                             req_cyc, state, bus_err, halted, illegal, bus.imem_req, TIMEOUT_CYC);
      end
`else
      @(negedge clk);
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk); #1;
         if (bus.imem_req) req_cyc++;
      end
      checks++;
      if (req_cyc != 1000 || state !== 3'd1 || bus_err !== 1'b0 || halted !== 1'b0) begin
         errors++; $display("FAIL no_timeout: got req_cyc=%0d state=%0d bus_err=%b halted=%b, required 1000,1,0,0",
                             req_cyc, state, bus_err, halted);
      end
`endif
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; opcode = '0;
      bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
      exp_cnt = '0;
      test_reset();
      test_op();
      test_load_store();
      test_branch();
      test_back_to_back();
      test_run_drop();
      test_wrap();
      test_async_reset();
      test_system_halt();
      test_illegal_halt();
      test_timeout();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d pending retirements, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
